// File: rtl/gravity_motion_ctrl.sv
// gravity_motion_ctrl: gravity-flip vertical motion sequencer.
// Optional FLIP_BUFFER_EN: buffer one flip pressed while airborne.
module gravity_motion_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int STEP     = 4,
    parameter int START_H  = 120,
    parameter int FLOOR_H  = 60,
    parameter int CEIL_H   = 360
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch,
    input  logic       restart,
    input  logic [2:0] lines,
    output logic [8:0] height,
    output logic       dir,
    output logic       landed,
    output logic       dead,
    output logic       flip_ack
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [8:0] START9 = 9'(START_H);
    localparam logic [8:0] FLOOR9 = 9'(FLOOR_H);
    localparam logic [8:0] CEIL9  = 9'(CEIL_H);

`ifdef FLIP_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    typedef enum logic [1:0] {
        LANDED = 2'd0,
        MOVE   = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          sw_q;
    logic          rise;
    logic          pend, pend_n;
    logic [8:0]    height_n, nh;
    logic          dir_n, ack_n;

    // Line support for a given rest height and gravity direction.
    function automatic logic rest_ok(
        input logic [8:0] h,
        input logic       d,
        input logic [2:0] ln
    );
        logic r;
        r = 1'b0;
        if (!d && h == 9'd120) r = ln[0];
        else if (!d && h == 9'd240) r = ln[1];
        else if (d && h == 9'd180) r = ln[1];
        else if (d && h == 9'd300) r = ln[2];
        return r;
    endfunction

    assign tick   = (cnt == CNT_MAX);
    assign rise   = switch & ~sw_q;
    assign landed = (state == LANDED);
    assign dead   = (state == DEAD);

    // Free-running motion tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // State, position and button history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LANDED;
            height   <= START9;
            dir      <= 1'b0;
            flip_ack <= 1'b0;
            sw_q     <= 1'b0;
            pend     <= 1'b0;
        end else if (restart) begin
            state    <= LANDED;
            height   <= START9;
            dir      <= 1'b0;
            flip_ack <= 1'b0;
            sw_q     <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state    <= state_n;
            height   <= height_n;
            dir      <= dir_n;
            flip_ack <= ack_n;
            sw_q     <= switch;
            pend     <= pend_n;
        end
    end

    // Next-state: flip beats line loss; motion only on ticks.
    always_comb begin
        state_n  = state;
        height_n = height;
        dir_n    = dir;
        ack_n    = 1'b0;
        pend_n   = pend;
        nh       = dir ? (height + STEP9) : (height - STEP9);
        case (state)
            LANDED: begin
                if (rise || pend) begin
                    dir_n   = ~dir;
                    ack_n   = 1'b1;
                    pend_n  = 1'b0;
                    state_n = MOVE;
                end else if (!rest_ok(height, dir, lines)) begin
                    state_n = MOVE;
                end
            end
            MOVE: begin
                if (rise && BUF) pend_n = 1'b1;
                if (tick) begin
                    if (rest_ok(nh, dir, lines)) begin
                        height_n = nh;
                        state_n  = LANDED;
                    end else if ((!dir && height < FLOOR9 + STEP9) ||
                                 (dir && nh > CEIL9)) begin
                        state_n = DEAD;
                        pend_n  = 1'b0;
                    end else begin
                        height_n = nh;
                    end
                end
            end
            DEAD: begin
                pend_n = 1'b0;
            end
            default: begin
                state_n = LANDED;
            end
        endcase
    end

endmodule

// File: tb/tb_gravity_motion_ctrl.sv
// tb_gravity_motion_ctrl: scoreboard bench with a behavioural model.
// Build with or without FLIP_BUFFER_EN; the model follows the macro.
module tb_gravity_motion_ctrl;

    localparam int TD    = 2;
    localparam int STP   = 4;
    localparam int START = 120;
    localparam int FLOOR = 60;
    localparam int CEIL  = 360;

`ifdef FLIP_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    typedef struct {
        int h;
        bit d;
        bit l;
        bit dd;
        bit a;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       switch;
    logic       restart;
    logic [2:0] lines;
    logic [8:0] height;
    logic       dir;
    logic       landed;
    logic       dead;
    logic       flip_ack;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    // Model state: mode 0 = resting, 1 = airborne, 2 = dead.
    int m_h    = START;
    bit m_dir  = 0;
    int m_mode = 0;
    int m_cnt  = 0;
    bit m_swq  = 0;
    bit m_pend = 0;
    bit m_ack  = 0;

    gravity_motion_ctrl #(
        .TICK_DIV(TD),
        .STEP(STP),
        .START_H(START),
        .FLOOR_H(FLOOR),
        .CEIL_H(CEIL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch(switch),
        .restart(restart),
        .lines(lines),
        .height(height),
        .dir(dir),
        .landed(landed),
        .dead(dead),
        .flip_ack(flip_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit supported(int h, bit d, logic [2:0] ln);
        if (!d) return (h == 120 && ln[0]) || (h == 240 && ln[1]);
        return (h == 180 && ln[1]) || (h == 300 && ln[2]);
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.h  = m_h;
        e.d  = m_dir;
        e.l  = (m_mode == 0);
        e.dd = (m_mode == 2);
        e.a  = m_ack;
        return e;
    endfunction

    task automatic model_reset();
        m_h    = START;
        m_dir  = 0;
        m_mode = 0;
        m_cnt  = 0;
        m_swq  = 0;
        m_pend = 0;
        m_ack  = 0;
    endtask

    task automatic model_step(bit sw, bit rst, bit rs, logic [2:0] ln);
        bit tick;
        bit rise;
        int nh;
        if (rst || rs) begin
            model_reset();
            return;
        end
        tick  = (m_cnt == TD - 1);
        rise  = sw && !m_swq;
        m_swq = sw;
        m_cnt = tick ? 0 : m_cnt + 1;
        m_ack = 0;
        if (m_mode == 2) begin
            m_pend = 0;
        end else if (m_mode == 0) begin
            if (rise || m_pend) begin
                m_dir  = !m_dir;
                m_ack  = 1;
                m_pend = 0;
                m_mode = 1;
            end else if (!supported(m_h, m_dir, ln)) begin
                m_mode = 1;
            end
        end else begin
            if (rise && BUF) m_pend = 1;
            if (tick) begin
                nh = m_dir ? m_h + STP : m_h - STP;
                if (supported(nh, m_dir, ln)) begin
                    m_h    = nh;
                    m_mode = 0;
                end else if (nh < FLOOR || nh > CEIL) begin
                    m_mode = 2;
                    m_pend = 0;
                end else begin
                    m_h = nh;
                end
            end
        end
    endtask

    task automatic compare(exp_t e, string tag);
        n_tests++;
        if (int'(height) != e.h || dir !== e.d || landed !== e.l ||
            dead !== e.dd || flip_ack !== e.a) begin
            n_fail++;
            $display("FAIL %s t=%0t got h=%0d d=%b l=%b dd=%b a=%b exp h=%0d d=%b l=%b dd=%b a=%b",
                     tag, $time, height, dir, landed, dead, flip_ack,
                     e.h, e.d, e.l, e.dd, e.a);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic cycle(bit sw, bit rs, logic [2:0] ln, bit rst);
        @(negedge clk);
        switch  = sw;
        restart = rs;
        lines   = ln;
        reset   = rst;
        model_step(sw, rst, rs, ln);
        q.push_back(snap());
    endtask

    task automatic run(int n, logic [2:0] ln);
        repeat (n) cycle(1'b0, 1'b0, ln, 1'b0);
    endtask

    // Monitor: compare each registered output set after its edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) compare(q.pop_front(), "edge");
    end

    initial begin
        exp_t e;
        int guard;
        logic [2:0] rl;
        reset   = 1'b1;
        switch  = 1'b0;
        restart = 1'b0;
        lines   = 3'b011;

        cycle(0, 0, 3'b011, 1);
        cycle(0, 0, 3'b011, 1);
        run(3, 3'b011);

        cycle(1, 0, 3'b011, 0);
        run(40, 3'b011);
        cycle(1, 0, 3'b011, 0);
        run(40, 3'b011);

        cycle(1, 0, 3'b100, 0);
        run(100, 3'b100);
        cycle(1, 0, 3'b010, 0);
        run(40, 3'b010);
        run(70, 3'b001);

        run(80, 3'b000);
        cycle(1, 0, 3'b000, 0);
        run(2, 3'b000);
        cycle(1, 0, 3'b011, 0);
        run(3, 3'b011);
        cycle(0, 1, 3'b011, 0);
        run(3, 3'b011);

        repeat (50) cycle(1, 0, 3'b011, 0);
        run(10, 3'b011);
        cycle(1, 0, 3'b001, 0);
        run(40, 3'b001);

        cycle(1, 0, 3'b011, 0);
        run(6, 3'b011);
        cycle(1, 0, 3'b011, 0);
        run(70, 3'b011);
        cycle(0, 1, 3'b011, 0);
        run(2, 3'b011);

        cycle(1, 0, 3'b011, 0);
        guard = 0;
        while (m_h != 152 && guard < 100) begin
            cycle(0, 0, 3'b011, 0);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL reach152 got h=%0d required 152", m_h);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        e = snap();
        compare(e, "async_reset");
        cycle(0, 0, 3'b011, 1);
        run(4, 3'b011);

        rl = 3'b011;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) rl = 3'($urandom_range(0, 7));
            cycle($urandom_range(0, 5) == 0,
                  (m_mode == 2) && ($urandom_range(0, 3) == 0),
                  rl, 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d left required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
